// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the device by holding PS2_CLK low, then issues a request-to-send
// with the start bit on PS2_DAT. On each device clock fall it shifts out the
// data bits (LSB first), then odd parity, then releases the line for the stop
// bit, and finally checks the device ACK. Both lines are open-drain: the block
// either pulls a line low or releases it to the external pull-up.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    // Counter is shared by the inhibit phase and the transfer watchdog.
    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    // One cycle before the last inhibit cycle; unreachable when INHIBIT_CYCLES is 1.
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    // With a single inhibit cycle the start bit must be driven from the accept edge.
    localparam logic INH_ONE = (INHIBIT_CYCLES == 1) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Line synchronizers; reset to 1 so an idle bus never produces a false fall.
    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_dat_meta;
    logic r_dat_sync;

    // Transmit state.
    state_t           r_state;
    logic [7:0]       r_shreg;
    logic             r_par;
    logic [3:0]       r_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    // Decoded conditions.
    logic w_fall;
    logic w_timeout;
    logic w_active;
    logic w_inh_last;
    logic w_inh_pre;
    logic w_lines_idle;
    logic w_accept;

    // Double-flop both bus lines and keep the previous clock sample for fall detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= PS2_CLK;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= PS2_DAT;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Ready is only offered in IDLE and is withdrawn immediately while reset is held.
    assign cmd_ready = (r_state == S_IDLE) && !reset;

    // Decode clock fall, counter terminal values, watchdog window and accept
    always_comb begin
        w_fall       = r_clk_prev & ~r_clk_sync;
        w_timeout    = (r_cnt == TO_LAST);
        w_inh_last   = (r_cnt == INH_LAST);
        w_inh_pre    = (r_cnt == INH_PRE);
        w_lines_idle = r_clk_sync & r_dat_sync;
        w_accept     = cmd_valid & cmd_ready;
        case (r_state)
            S_REQ, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE: w_active = 1'b1;
            default:                                       w_active = 1'b0;
        endcase
    end

    // Transmit sequencer: inhibit, request, bit shifting, ACK check, watchdog and completion pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shreg  <= 8'h00;
            r_par    <= 1'b0;
            r_n      <= 4'd0;
            r_cnt    <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses unless set below.
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_active && w_timeout) begin
                // Watchdog wins over any clock fall in the same cycle.
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_error  <= 1'b1;
                r_state  <= S_IDLE;
            end else begin
                if (w_active) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                case (r_state)
                    S_IDLE: begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        if (w_accept) begin
                            r_shreg  <= cmd_data;
                            r_par    <= odd_parity(cmd_data);
                            r_n      <= 4'd0;
                            r_cnt    <= '0;
                            r_clk_oe <= 1'b1;
                            r_dat_oe <= INH_ONE;
                            r_busy   <= 1'b1;
                            r_state  <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (w_inh_last) begin
                            // Release the clock with the start bit held: request-to-send.
                            r_cnt    <= '0;
                            r_clk_oe <= 1'b0;
                            r_dat_oe <= 1'b1;
                            r_state  <= S_REQ;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_inh_pre) begin
                                // Start bit appears in the final inhibit cycle.
                                r_dat_oe <= 1'b1;
                            end
                        end
                    end
                    S_REQ: begin
                        if (w_fall) begin
                            r_dat_oe <= ~r_shreg[0];
                            r_shreg  <= {1'b0, r_shreg[7:1]};
                            r_n      <= 4'd1;
                            r_state  <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_fall) begin
                            if (r_n < 4'd8) begin
                                r_dat_oe <= ~r_shreg[0];
                                r_shreg  <= {1'b0, r_shreg[7:1]};
                                r_n      <= r_n + 4'd1;
                            end else begin
                                r_dat_oe <= ~r_par;
                                r_state  <= S_PARITY;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_fall) begin
                            // Stop bit is a 1, produced by releasing the line.
                            r_dat_oe <= 1'b0;
                            r_state  <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_fall) begin
                            if (r_dat_sync) begin
                                // Device did not pull data low: NACK.
                                r_busy  <= 1'b0;
                                r_error <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_WAIT_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_lines_idle) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    // Open-drain drivers: pull low or release.
    assign PS2_CLK = r_clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = r_dat_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a behavioural PS/2
// device that clocks the frame and samples data on rising clock edges.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 3000;
    localparam int HALF = 40;

    logic       clk;
    logic       reset;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       error;
    wire        ps2_clk;
    wire        ps2_dat;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_error  = 0;
    int n_both   = 0;
    int hold_left = 0;

    // Device model state.
    bit         dev_enable  = 1'b1;
    bit         dev_ack     = 1'b1;
    bit         dev_abort   = 1'b0;
    bit         dev_active  = 1'b0;
    bit         dev_clk_low = 1'b0;
    bit         dev_dat_low = 1'b0;
    logic [9:0] dev_bits    = '0;
    int         dev_nbits   = 0;
    int         dev_frames  = 0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Count completion pulses away from the active edge.
    always @(negedge clk) begin
        if (done)          n_done++;
        if (error)         n_error++;
        if (done && error) n_both++;
    end

    // Device: waits for request-to-send, then generates 11 clock pulses.
    initial begin : device_model
        forever begin
            @(negedge clk);
            if (dev_enable && !dev_abort && ps2_clk === 1'b1 && ps2_dat === 1'b0) begin
                dev_active = 1'b1;
                dev_nbits  = 0;
                dev_bits   = '0;
                repeat (HALF) @(negedge clk);
                for (int i = 0; i < 11; i++) begin
                    if (!dev_abort) begin
                        if (i == 10 && dev_ack) dev_dat_low = 1'b1;
                        dev_clk_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        dev_clk_low = 1'b0;
                        if (i < 10) begin
                            dev_bits[i] = ps2_dat;
                            dev_nbits++;
                        end
                        repeat (HALF) @(negedge clk);
                        dev_dat_low = 1'b0;
                    end
                end
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                dev_frames++;
                dev_active = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hold_left > 0) begin
            hold_left--;
            cmd_data = cmd_data + 8'h35;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_dev_idle();
        int k;
        k = 0;
        while (dev_active && k < 3000) begin
            tick();
            k++;
        end
        chk("device_idle_bound", int'(dev_active), 0);
    endtask

    // Accept a byte, measure inhibit, then wait for done/error.
    task automatic do_send(input logic [7:0] d, input int hold,
                           output int kind, output int req_cycles);
        int k;
        int first_low;
        wait_dev_idle();
        chk("cmd_ready_before_accept", int'(cmd_ready), 1);
        cmd_data  = d;
        cmd_valid = 1'b1;
        hold_left = hold;
        tick();
        chk("busy_after_accept", int'(busy), 1);
        k = 0;
        first_low = -1;
        while (ps2_clk === 1'b0 && k < 1000) begin
            if (ps2_dat === 1'b0 && first_low < 0) first_low = k;
            tick();
            k++;
        end
        chk("inhibit_length", k, INH);
        chk("start_bit_cycle", first_low, INH - 1);
        req_cycles = 0;
        while (!(done || error) && req_cycles < TO + 500) begin
            tick();
            req_cycles++;
        end
        kind = done ? 1 : (error ? 2 : 0);
        chk("pulse_seen", int'(kind != 0), 1);
        chk("busy_at_pulse", int'(busy), 0);
        chk("ready_at_pulse", int'(cmd_ready), 1);
        chk("pulse_exclusive", int'(done && error), 0);
        tick();
        chk("pulse_width", int'(done || error), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        int         exp_kind;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        int kind;
        int rc;
        int frames0;
        int d0;
        int e0;
        int k;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1};
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 2};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        repeat (3) tick();
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_clk_released", int'(ps2_clk === 1'b1), 1);
        chk("reset_dat_released", int'(ps2_dat === 1'b1), 1);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", int'(cmd_ready), 1);
        tick();

        // Table-driven sends; entries 1 and 2 run back-to-back.
        for (int v = 0; v < 6; v++) begin
            dev_ack = vecs[v].ack;
            frames0 = dev_frames;
            do_send(vecs[v].data, 0, kind, rc);
            chk("outcome", kind, vecs[v].exp_kind);
            chk("rx_byte", int'(dev_bits[7:0]), int'(vecs[v].data));
            chk("rx_parity", int'(dev_bits[8]), int'(vecs[v].exp_par));
            chk("rx_stop", int'(dev_bits[9]), 1);
            wait_dev_idle();
            chk("frame_count", dev_frames - frames0, 1);
            chk("clk_released_after", int'(ps2_clk === 1'b1), 1);
            chk("dat_released_after", int'(ps2_dat === 1'b1), 1);
        end
        dev_ack = 1'b1;

        // cmd_valid held with changing data while busy: only 0x3C goes out.
        d0 = n_done;
        do_send(8'h3C, 300, kind, rc);
        chk("hold_outcome", kind, 1);
        chk("hold_rx_byte", int'(dev_bits[7:0]), 8'h3C);
        chk("hold_rx_parity", int'(dev_bits[8]), 1);
        repeat (5) tick();
        chk("hold_single_done", n_done - d0, 1);
        chk("hold_idle_after", int'(busy), 0);

        // Device never clocks: watchdog error TO cycles after REQ entry.
        dev_enable = 1'b0;
        do_send(8'h55, 0, kind, rc);
        chk("timeout_outcome", kind, 2);
        chk("timeout_cycles", rc, TO);
        chk("timeout_clk_released", int'(ps2_clk === 1'b1), 1);
        chk("timeout_dat_released", int'(ps2_dat === 1'b1), 1);
        dev_enable = 1'b1;

        // Reset during bit 4 of 0x0F (bit 4 = 0, line driven low).
        wait_dev_idle();
        cmd_data  = 8'h0F;
        cmd_valid = 1'b1;
        tick();
        k = 0;
        while (!(dev_nbits == 4 && dev_clk_low) && k < 3000) begin
            tick();
            k++;
        end
        chk("reach_bit4_bound", int'(k < 3000), 1);
        repeat (10) tick();
        chk("bit4_driven_low", int'(ps2_dat === 1'b0), 1);
        d0 = n_done;
        e0 = n_error;
        dev_abort = 1'b1;
        reset = 1'b1;
        tick();
        chk("rst_dat_released", int'(ps2_dat === 1'b1), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready_low", int'(cmd_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        reset = 1'b0;
        repeat (200) tick();
        wait_dev_idle();
        dev_abort = 1'b0;
        chk("rst_no_done_pulse", n_done - d0, 0);
        chk("rst_no_error_pulse", n_error - e0, 0);
        chk("rst_clk_released", int'(ps2_clk === 1'b1), 1);

        do_send(8'hFF, 0, kind, rc);
        chk("post_reset_outcome", kind, 1);
        chk("post_reset_rx_byte", int'(dev_bits[7:0]), 8'hFF);
        chk("post_reset_parity", int'(dev_bits[8]), 1);

        repeat (5) tick();
        chk("total_done_pulses", n_done, 7);
        chk("total_error_pulses", n_error, 2);
        chk("done_error_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
